// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_pkg
//  Description : Shared types and constants for the instruction-memory loader:
//                symbolic op codes, MIPS opcode/funct values, FSM state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    // Symbolic operation requested by the controller; 12..15 are illegal
    typedef enum logic [3:0] {
        OP_LW   = 4'd0,
        OP_SW   = 4'd1,
        OP_J    = 4'd2,
        OP_JAL  = 4'd3,
        OP_BNE  = 4'd4,
        OP_BEQ  = 4'd5,
        OP_XORI = 4'd6,
        OP_ADDI = 4'd7,
        OP_ADD  = 4'd8,
        OP_SUB  = 4'd9,
        OP_SLT  = 4'd10,
        OP_JR   = 4'd11
    } op_e;

    // Primary opcodes, identical to the values the decoder matches on
    localparam logic [5:0] c_opc_special = 6'h00;
    localparam logic [5:0] c_opc_j       = 6'h02;
    localparam logic [5:0] c_opc_jal     = 6'h03;
    localparam logic [5:0] c_opc_beq     = 6'h04;
    localparam logic [5:0] c_opc_bne     = 6'h05;
    localparam logic [5:0] c_opc_addi    = 6'h08;
    localparam logic [5:0] c_opc_xori    = 6'h0E;
    localparam logic [5:0] c_opc_lw      = 6'h23;
    localparam logic [5:0] c_opc_sw      = 6'h2B;

    // Funct field values for SPECIAL-opcode instructions
    localparam logic [5:0] c_funct_jr    = 6'h08;
    localparam logic [5:0] c_funct_add   = 6'h20;
    localparam logic [5:0] c_funct_sub   = 6'h22;
    localparam logic [5:0] c_funct_slt   = 6'h2A;

    // Loader session state
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : instr_encoder
//  Description : Combinational MIPS encoder: symbolic op plus register,
//                immediate and target fields -> 32-bit machine word.
//                Flags op codes outside the defined set as illegal.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_encoder
    import imem_loader_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] word,
    output logic        illegal
);

    // Select the instruction format and fill its fields; shamt is always zero
    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (op)
            OP_LW:   word = {c_opc_lw,   rs, rt, imm};
            OP_SW:   word = {c_opc_sw,   rs, rt, imm};
            OP_BEQ:  word = {c_opc_beq,  rs, rt, imm};
            OP_BNE:  word = {c_opc_bne,  rs, rt, imm};
            OP_ADDI: word = {c_opc_addi, rs, rt, imm};
            OP_XORI: word = {c_opc_xori, rs, rt, imm};
            OP_J:    word = {c_opc_j,   target};
            OP_JAL:  word = {c_opc_jal, target};
            OP_ADD:  word = {c_opc_special, rs, rt, rd, 5'd0, c_funct_add};
            OP_SUB:  word = {c_opc_special, rs, rt, rd, 5'd0, c_funct_sub};
            OP_SLT:  word = {c_opc_special, rs, rt, rd, 5'd0, c_funct_slt};
            OP_JR:   word = {c_opc_special, rs, 5'd0, 5'd0, 5'd0, c_funct_jr};
            default: illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Encodes symbolic instruction requests and writes them to
//                sequential instruction-memory addresses through a 2-entry
//                buffer, with per-session capacity limiting.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int                ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_gnt,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [ADDR_W:0] c_cap    = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] c_cap_m1 = {1'b0, {ADDR_W{1'b1}}};

    state_e            r_state;
    state_e            w_state_nxt;
    logic              r_head_v;
    logic              r_tail_v;
    logic [ADDR_W-1:0] r_head_addr;
    logic [ADDR_W-1:0] r_tail_addr;
    logic [31:0]       r_head_word;
    logic [31:0]       r_tail_word;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [ADDR_W:0]   r_acc_cnt;
    logic [ADDR_W:0]   r_count;
    logic              r_err;
    logic [31:0]       w_enc_word;
    logic              w_illegal;
    logic              w_accept;
    logic              w_push;
    logic              w_pop;
    logic              w_last;
    logic              w_start;

    instr_encoder u_enc (
        .op      (in_op),
        .rs      (in_rs),
        .rt      (in_rt),
        .rd      (in_rd),
        .imm     (in_imm),
        .target  (in_target),
        .word    (w_enc_word),
        .illegal (w_illegal)
    );

    assign w_accept = in_valid & in_ready;
    assign w_push   = w_accept & ~w_illegal;
    assign w_pop    = r_head_v & imem_gnt;
    assign w_last   = w_push & (r_acc_cnt == c_cap_m1);
    assign w_start  = (r_state == ST_IDLE) & start;

    // Session state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next state plus in_ready/done; in_ready uses registered state only
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                in_ready = ~(r_head_v & r_tail_v) & (r_acc_cnt < c_cap);
                if (finish || w_last) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!r_head_v) begin
                    done        = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Write pointer, accepted/written counters and sticky error flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_addr <= BASE_ADDR;
            r_acc_cnt <= '0;
            r_count   <= '0;
            r_err     <= 1'b0;
        end else if (w_start) begin
            r_wr_addr <= BASE_ADDR;
            r_acc_cnt <= '0;
            r_count   <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_accept && w_illegal) r_err <= 1'b1;
            if (w_push) begin
                r_wr_addr <= r_wr_addr + ADDR_W'(1);
                r_acc_cnt <= r_acc_cnt + (ADDR_W+1)'(1);
            end
            if (w_pop) r_count <= r_count + (ADDR_W+1)'(1);
        end
    end

    // Two-entry FIFO kept as head/tail registers so the memory port is driven from flops
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head_v    <= 1'b0;
            r_tail_v    <= 1'b0;
            r_head_addr <= BASE_ADDR;
            r_tail_addr <= BASE_ADDR;
            r_head_word <= '0;
            r_tail_word <= '0;
        end else if (w_start) begin
            r_head_v <= 1'b0;
            r_tail_v <= 1'b0;
        end else if (w_pop && r_tail_v) begin
            r_head_addr <= r_tail_addr;
            r_head_word <= r_tail_word;
            r_tail_v    <= w_push;
            if (w_push) begin
                r_tail_addr <= r_wr_addr;
                r_tail_word <= w_enc_word;
            end
        end else if (w_pop) begin
            r_head_v <= w_push;
            if (w_push) begin
                r_head_addr <= r_wr_addr;
                r_head_word <= w_enc_word;
            end
        end else if (w_push) begin
            if (r_head_v) begin
                r_tail_v    <= 1'b1;
                r_tail_addr <= r_wr_addr;
                r_tail_word <= w_enc_word;
            end else begin
                r_head_v    <= 1'b1;
                r_head_addr <= r_wr_addr;
                r_head_word <= w_enc_word;
            end
        end
    end

    assign imem_we    = r_head_v;
    assign imem_addr  = r_head_addr;
    assign imem_wdata = r_head_word;
    assign count      = r_count;
    assign busy       = (r_state != ST_IDLE);
    assign err        = r_err;

endmodule
`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Encodes symbolic MIPS instruction requests (operation plus register, immediate and target fields) into 32-bit machine words and writes them sequentially into instruction memory. It is the write-side counterpart of the instruction decoder: every word it emits decodes back to the same fields. It sits between the test/boot controller and the instruction memory write port, buffering up to two words while the memory port is not granted.

## Interface

Parameters:
- ADDR_W, 10, instruction memory word-address width; capacity is 2^ADDR_W words.
- BASE_ADDR, 0, first word address written after `start`.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a load session; honoured only in IDLE.
- finish  in  1  end of program; honoured only in LOAD.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted on a cycle with `in_valid & in_ready`.
- in_op  in  4  operation code: LW=0, SW=1, J=2, JAL=3, BNE=4, BEQ=5, XORI=6, ADDI=7, ADD=8, SUB=9, SLT=10, JR=11; 12–15 are illegal.
- in_rs, in_rt, in_rd  in  5 each  register fields.
- in_imm  in  16  immediate.
- in_target  in  26  jump target.
- imem_we  out  1  write request; the buffer head is valid.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  encoded word.
- imem_gnt  in  1  the write completes on a cycle with `imem_we & imem_gnt`.
- count  out  ADDR_W+1  words written in the current session.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse when a session ends.
- err  out  1  sticky flag for an illegal op; cleared by `start`.

## Operation

**States**
- IDLE: `in_ready` is 0.
  - `start` → LOAD. Write pointer = BASE_ADDR; `count`, `err` and the buffer are cleared.
- LOAD: `in_ready` = buffer occupancy < 2 AND (accepted words < 2^ADDR_W).
  - Go to DRAIN when `finish` is high, or on the acceptance that makes accepted words equal 2^ADDR_W.
- DRAIN: `in_ready` is 0.
  - When the buffer is empty → IDLE with `done` = 1 for that one cycle.
  - If DRAIN is entered with the buffer already empty, the move to IDLE happens on the next cycle.

**Encoding** (shamt is always 0)
- R-type (ADD/SUB/SLT): {6'h00, rs, rt, rd, 5'd0, funct}, where funct is 0x20, 0x22 or 0x2A respectively.
- JR: {6'h00, rs, 5'd0, 5'd0, 5'd0, 6'h08}.
- I-type: {opcode, rs, rt, imm}, where opcode is LW 0x23, SW 0x2B, BEQ 0x04, BNE 0x05, ADDI 0x08, XORI 0x0E.
- J/JAL: {opcode 0x02/0x03, target}.
- Illegal op: the request is accepted and dropped. Nothing is buffered, the pointer does not advance, and `err` is set.

**Buffer and address**
- The buffer is a 2-entry FIFO of {addr, word}. The address is assigned at acceptance from the write pointer, and the pointer then increments by 1.
- The pointer wraps modulo 2^ADDR_W. Capacity limiting prevents any overwrite inside a session.
- `count` increments on each completed write.

**Priority and reset**
- `start` and `finish` outside their states are ignored.
- A push and a pop in the same cycle leave occupancy unchanged.
- Reset mid-session discards buffered words and clears everything.

## Timing

- Reset values: state IDLE; `in_ready`, `imem_we`, `busy`, `done`, `err` = 0; `count` = 0; `imem_addr` = BASE_ADDR; `imem_wdata` = 0.
- Latency: a request accepted at edge N drives `imem_we`=1 with its word and address from cycle N+1.
- `imem_addr` and `imem_wdata` are registered and stay stable while `imem_we & ~imem_gnt`.
- With `imem_gnt` held high, throughput is 1 word per cycle.
- `in_ready` depends only on registered state. There is no combinational path from `imem_gnt` or `in_valid`.
- `busy` goes high the cycle after `start`. `err` is visible the cycle after the illegal acceptance.

## Structure

- A shared package holds:
  - the op-code enumeration (0–11);
  - the MIPS opcode and funct constants (the same values the decoder uses);
  - the FSM state type.
- Sub-module `instr_encoder`: purely combinational op/fields → {word, illegal}. It can be reused by the bench as a reference model.
- The FIFO lives inline in the top module.

## Test plan

- Reset, `start`, then ADD rs=1 rt=2 rd=3 with `imem_gnt`=1 → word 0x00221820 at addr 0; `imem_we` high exactly one cycle after acceptance; `count`=1.
- Back-to-back ADDI rs=0 rt=8 imm=0xFFFF, then J target=0x0000010, then JR rs=31 → words 0x2008FFFF, 0x08000010, 0x03E00008 at addrs 0, 1, 2; one per cycle.
- Hold `imem_gnt`=0 for 5 cycles while streaming → `in_ready` drops after 2 acceptances and address/data stay stable; on release the words drain in order with no loss.
- in_op=13 between two LW → `err` set; the LW words land at consecutive addresses 0 and 1; `count`=2.
- ADDR_W=2: stream 6 requests → exactly 4 accepted; automatic DRAIN; `done` pulses once after the 4th write; `count`=4.
- Assert reset_n low with 2 words buffered → `imem_we` drops immediately; after reset the state is IDLE and `count`=0.
